// File: rtl/pong_pkg.sv
// pong_pkg: game state encoding and screen/geometry defaults shared by the
// game engine and the video encoder.
package pong_pkg;

  typedef enum logic [1:0] {IDLE, PLAY, MISS, OVER} state_t;

  localparam int SCREEN_W     = 800;
  localparam int SCREEN_H     = 600;
  localparam int BALL_SIZE    = 8;
  localparam int PADDLE_W     = 80;
  localparam int PADDLE_H     = 10;
  localparam int PADDLE_Y     = 560;
  localparam int BALL_SPEED   = 2;
  localparam int PADDLE_SPEED = 4;
  localparam int MISS_FRAMES  = 60;
  localparam int MAX_LIVES    = 3;

  localparam logic [10:0] PADDLE_X0 = 11'((SCREEN_W - PADDLE_W) / 2);

  function automatic logic [5:0] sat_inc(input logic [5:0] v);
    return (v == 6'd63) ? v : v + 6'd1;
  endfunction

endpackage

// File: rtl/paddle_ctrl.sv
// paddle_ctrl: button synchronizers and per-frame paddle move with edge clamp.
module paddle_ctrl
  import pong_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        en,
  input  logic        btn_left,
  input  logic        btn_right,
  output logic [10:0] paddle_x,
  output logic [10:0] paddle_nx
);

  localparam logic signed [12:0] STEP  = 13'(PADDLE_SPEED);
  localparam logic signed [12:0] X_MAX = 13'(SCREEN_W - PADDLE_W);

  logic [1:0] left_sync, right_sync;
  logic go_left, go_right;
  logic signed [12:0] moved;

  always_comb begin
    go_left   = en && left_sync[1] && !right_sync[1];
    go_right  = en && right_sync[1] && !left_sync[1];
    moved     = $signed({2'b00, paddle_x}) + (go_left ? -STEP : go_right ? STEP : 13'sd0);
    paddle_nx = (moved < 13'sd0) ? 11'd0 : (moved > X_MAX) ? X_MAX[10:0] : moved[10:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      left_sync  <= '0;
      right_sync <= '0;
      paddle_x   <= PADDLE_X0;
    end else begin
      left_sync  <= {left_sync[0], btn_left};
      right_sync <= {right_sync[0], btn_right};
      if (frame_tick) paddle_x <= paddle_nx;
    end
  end

endmodule

// File: rtl/pong_game_engine.sv
// pong_game_engine: frame-rate ball/paddle game (positions, score, lives).
// Define SPEEDUP_EN to add one px/frame of ball speed per 8 paddle hits.
module pong_game_engine
  import pong_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        serve,
  output logic [10:0] ball_x,
  output logic [10:0] ball_y,
  output logic [10:0] paddle_x,
  output logic [10:0] paddle_y,
  output logic [5:0]  score,
  output logic [5:0]  lives,
  output logic        game_over
);

  localparam logic signed [12:0] BX_MAX  = 13'(SCREEN_W - BALL_SIZE);
  localparam logic signed [12:0] BY_MISS = 13'(SCREEN_H - BALL_SIZE);
  localparam logic signed [12:0] P_TOP   = 13'(PADDLE_Y);
  localparam logic signed [12:0] P_BOT   = 13'(PADDLE_Y + PADDLE_H);
  localparam logic signed [12:0] BSZ     = 13'(BALL_SIZE);
  localparam logic [10:0] PW       = 11'(PADDLE_W);
  localparam logic [10:0] BS       = 11'(BALL_SIZE);
  localparam logic [10:0] RIDE_OFS = 11'((PADDLE_W - BALL_SIZE) / 2);
  localparam logic [10:0] REST_Y   = 11'(PADDLE_Y - BALL_SIZE);
  localparam logic [5:0]  LIVES0   = 6'(MAX_LIVES);
  localparam logic [5:0]  MISS_END = 6'(MISS_FRAMES - 1);

  state_t state;
  logic [1:0] serve_sync;
  logic serve_s, dx, dy_up, cdx, cdy, hit_l, hit_r, hit_t, hit_p, miss, ndx, ndy;
  logic [5:0] cnt;
  logic [3:0] spd;
  logic [10:0] paddle_nx, wx, wy, ride_x;
  logic signed [12:0] sp, nx, ny, bot;

  paddle_ctrl u_paddle (
    .clk(clk),
    .rst(rst),
    .frame_tick(frame_tick),
    .en(state != OVER),
    .btn_left(btn_left),
    .btn_right(btn_right),
    .paddle_x(paddle_x),
    .paddle_nx(paddle_nx)
  );

  assign paddle_y = 11'(PADDLE_Y);

  always_comb begin
    serve_s = serve_sync[1];
`ifdef SPEEDUP_EN
    spd = 4'(BALL_SPEED) + {1'b0, score[5:3]};
`else
    spd = 4'(BALL_SPEED);
`endif
    sp     = $signed({9'd0, spd});
    // A serve launches up-right from the riding position on the same tick.
    cdx    = (state == PLAY) ? dx : 1'b1;
    cdy    = (state == PLAY) ? dy_up : 1'b1;
    nx     = cdx ? $signed({2'b00, ball_x}) + sp : $signed({2'b00, ball_x}) - sp;
    ny     = cdy ? $signed({2'b00, ball_y}) - sp : $signed({2'b00, ball_y}) + sp;
    hit_l  = nx <= 13'sd0;
    hit_r  = nx >= BX_MAX;
    hit_t  = ny <= 13'sd0;
    wx     = hit_l ? 11'd0 : hit_r ? BX_MAX[10:0] : nx[10:0];
    wy     = hit_t ? 11'd0 : ny[10:0];
    bot    = ny + BSZ;
    hit_p  = !cdy && bot >= P_TOP && bot <= P_BOT && (wx + BS > paddle_x) && (wx < paddle_x + PW);
    miss   = !hit_p && ny >= BY_MISS;
    ndx    = hit_l ? 1'b1 : hit_r ? 1'b0 : cdx;
    ndy    = hit_t ? 1'b0 : hit_p ? 1'b1 : cdy;
    ride_x = paddle_nx + RIDE_OFS;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      serve_sync <= '0;
      state      <= IDLE;
      ball_x     <= PADDLE_X0 + RIDE_OFS;
      ball_y     <= REST_Y;
      dx         <= 1'b1;
      dy_up      <= 1'b1;
      score      <= '0;
      lives      <= LIVES0;
      game_over  <= 1'b0;
      cnt        <= '0;
    end else begin
      serve_sync <= {serve_sync[0], serve};
      if (frame_tick) begin
        case (state)
          IDLE: begin
            ball_x <= serve_s ? wx : ride_x;
            ball_y <= serve_s ? wy : REST_Y;
            dx     <= serve_s ? ndx : 1'b1;
            dy_up  <= serve_s ? ndy : 1'b1;
            if (serve_s) state <= PLAY;
          end
          PLAY: begin
            ball_x <= wx;
            ball_y <= hit_p ? REST_Y : wy;
            dx     <= ndx;
            dy_up  <= ndy;
            if (hit_p) score <= sat_inc(score);
            if (miss) begin
              lives <= lives - 6'd1;
              cnt   <= '0;
              state <= MISS;
            end
          end
          MISS: begin
            if (cnt == MISS_END) begin
              state     <= (lives != 6'd0) ? IDLE : OVER;
              game_over <= lives == 6'd0;
              if (lives != 6'd0) begin
                ball_x <= ride_x;
                ball_y <= REST_Y;
                dx     <= 1'b1;
                dy_up  <= 1'b1;
              end
            end else begin
              cnt <= cnt + 6'd1;
            end
          end
          OVER: begin
            if (serve_s) begin
              state     <= IDLE;
              game_over <= 1'b0;
              score     <= '0;
              lives     <= LIVES0;
              ball_x    <= ride_x;
              ball_y    <= REST_Y;
              dx        <= 1'b1;
              dy_up     <= 1'b1;
            end
          end
        endcase
      end
    end
  end

endmodule
